// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiply controller.
// It takes WIDTH iterations, then writes the 2*WIDTH-bit product for one cycle.
`default_nettype none

module mul_sequencer #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Start,
  input  logic                 Signed,
  input  logic                 Cancel,
  input  logic [WIDTH-1:0]     OperandA,
  input  logic [WIDTH-1:0]     OperandB,
  output logic                 Busy,
  output logic                 Done,
  output logic                 MulRegWrite,
  output logic [2*WIDTH-1:0]   MulRegData
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   data_q;
  logic                 busy_q;
  logic                 write_q;

  logic [WIDTH-1:0]     mag_a_d;
  logic [WIDTH-1:0]     mag_b_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_d;

  // Magnitudes fit in WIDTH bits unsigned, including the most negative value.
  always_comb begin
    mag_a_d = (Signed && OperandA[WIDTH-1]) ? (~OperandA + 1'b1) : OperandA;
    mag_b_d = (Signed && OperandB[WIDTH-1]) ? (~OperandB + 1'b1) : OperandB;
    acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod_d  = neg_q ? (~acc_d + 1'b1) : acc_d;
  end

  // mcand_q is kept pre-shifted, so it always equals multiplicand << cnt_q.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
            mplier_q <= mag_b_d;
            neg_q    <= Signed & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (Cancel) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              data_q  <= prod_d;
              write_q <= 1'b1;
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy        = busy_q;
  assign Done        = write_q;
  assign MulRegWrite = write_q;
  assign MulRegData  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench for mul_sequencer.
`default_nettype none

module tb_mul_sequencer;

  logic        Clock;
  logic        ResetN;
  logic        Start;
  logic        Signed;
  logic        Cancel;
  logic [23:0] OperandA;
  logic [23:0] OperandB;
  logic        Busy;
  logic        Done;
  logic        MulRegWrite;
  logic [47:0] MulRegData;

  int nchk  = 0;
  int nfail = 0;
  int n;
  int w;

  mul_sequencer #(.WIDTH(24), .CNT_W(5)) dut (
    .Clock       (Clock),
    .ResetN      (ResetN),
    .Start       (Start),
    .Signed      (Signed),
    .Cancel      (Cancel),
    .OperandA    (OperandA),
    .OperandB    (OperandB),
    .Busy        (Busy),
    .Done        (Done),
    .MulRegWrite (MulRegWrite),
    .MulRegData  (MulRegData)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the WRITE cycle.
  task automatic do_mul(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input logic s, input logic cancel_too, input logic [47:0] exp);
    int cyc;
    OperandA = a;
    OperandB = b;
    Signed   = s;
    Start    = 1'b1;
    Cancel   = cancel_too;
    @(negedge Clock);
    Start  = 1'b0;
    Cancel = 1'b0;
    chk({tag, "_busy_rise"}, 48'(Busy), 48'd1);
    cyc = 0;
    while (!MulRegWrite && cyc < 40) begin
      @(negedge Clock);
      cyc++;
    end
    chk({tag, "_latency"}, 48'(cyc), 48'd24);
    chk({tag, "_done"}, 48'(Done), 48'd1);
    chk({tag, "_data"}, MulRegData, exp);
    @(negedge Clock);
    chk({tag, "_idle_busy"}, 48'(Busy), 48'd0);
    chk({tag, "_idle_wr"}, 48'(MulRegWrite), 48'd0);
    chk({tag, "_hold"}, MulRegData, exp);
  endtask

  initial begin
    ResetN   = 1'b0;
    Start    = 1'b0;
    Signed   = 1'b0;
    Cancel   = 1'b0;
    OperandA = '0;
    OperandB = '0;
    #2;
    chk("rst_busy", 48'(Busy), 48'd0);
    chk("rst_done", 48'(Done), 48'd0);
    chk("rst_wr", 48'(MulRegWrite), 48'd0);
    chk("rst_data", MulRegData, 48'd0);
    @(negedge Clock);
    ResetN = 1'b1;

    // Basic products, signed/unsigned, extremes; Start beats Cancel in IDLE
    do_mul("u3x5", 24'd3, 24'd5, 1'b0, 1'b1, 48'h0000_0000_000F);
    do_mul("sm3x5", 24'hFFFFFD, 24'd5, 1'b1, 1'b0, 48'hFFFF_FFFF_FFF1);
    do_mul("uFFFFFDx5", 24'hFFFFFD, 24'd5, 1'b0, 1'b0, 48'h0000_04FF_FFF1);
    do_mul("umax", 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 48'hFFFF_FE00_0001);
    do_mul("smin_sq", 24'h800000, 24'h800000, 1'b1, 1'b0, 48'h4000_0000_0000);
    do_mul("smin_x1", 24'h800000, 24'h000001, 1'b1, 1'b0, 48'hFFFF_FF80_0000);

    // Start held high with changing operands: only the accepted operands count
    OperandA = 24'd2;
    OperandB = 24'd3;
    Signed   = 1'b0;
    Start    = 1'b1;
    @(negedge Clock);
    chk("hold1_busy", 48'(Busy), 48'd1);
    n = 0;
    while (!MulRegWrite && n < 40) begin
      OperandA = 24'($urandom);
      OperandB = 24'($urandom);
      @(negedge Clock);
      n++;
    end
    chk("hold1_latency", 48'(n), 48'd24);
    chk("hold1_data", MulRegData, 48'd6);
    OperandA = 24'($urandom);
    @(negedge Clock);
    chk("hold_gap_idle", 48'(Busy), 48'd0);
    OperandA = 24'h000100;
    OperandB = 24'h000010;
    @(negedge Clock);
    chk("hold2_busy", 48'(Busy), 48'd1);
    n = 0;
    while (!MulRegWrite && n < 40) begin
      OperandA = 24'($urandom);
      OperandB = 24'($urandom);
      @(negedge Clock);
      n++;
    end
    chk("hold2_latency", 48'(n), 48'd24);
    chk("hold2_data", MulRegData, 48'h0000_0000_1000);
    Start = 1'b0;
    @(negedge Clock);
    chk("hold2_idle", 48'(Busy), 48'd0);

    // Cancel during iteration 10
    OperandA = 24'd11;
    OperandB = 24'd13;
    Start    = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (9) @(negedge Clock);
    Cancel = 1'b1;
    @(negedge Clock);
    Cancel = 1'b0;
    chk("cancel_busy", 48'(Busy), 48'd0);
    chk("cancel_done", 48'(Done), 48'd0);
    chk("cancel_data", MulRegData, 48'h0000_0000_1000);
    w = 0;
    repeat (30) begin
      @(negedge Clock);
      if (MulRegWrite) w++;
    end
    chk("cancel_nowrite", 48'(w), 48'd0);
    do_mul("after_cancel", 24'd11, 24'd13, 1'b0, 1'b0, 48'd143);

    // Asynchronous reset mid-RUN
    OperandA = 24'd3;
    OperandB = 24'd5;
    Start    = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (5) @(negedge Clock);
    #2 ResetN = 1'b0;
    #1;
    chk("arst_run_busy", 48'(Busy), 48'd0);
    chk("arst_run_data", MulRegData, 48'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    w = 0;
    repeat (30) begin
      @(negedge Clock);
      if (MulRegWrite) w++;
    end
    chk("arst_run_nowrite", 48'(w), 48'd0);

    // Asynchronous reset during WRITE
    OperandA = 24'd2;
    OperandB = 24'd2;
    Start    = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    n = 0;
    while (!MulRegWrite && n < 40) begin
      @(negedge Clock);
      n++;
    end
    chk("arst_wr_reached", 48'(MulRegWrite), 48'd1);
    #2 ResetN = 1'b0;
    #1;
    chk("arst_wr_wr", 48'(MulRegWrite), 48'd0);
    chk("arst_wr_done", 48'(Done), 48'd0);
    chk("arst_wr_busy", 48'(Busy), 48'd0);
    chk("arst_wr_data", MulRegData, 48'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    w = 0;
    repeat (30) begin
      @(negedge Clock);
      if (MulRegWrite) w++;
    end
    chk("arst_wr_nowrite", 48'(w), 48'd0);
    do_mul("u7x9", 24'd7, 24'd9, 1'b0, 1'b0, 48'd63);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire
